// File: rtl/arp_pkg.sv
// Shared types for the set-associative ARP cache.
// Holds the address/MAC widths, the per-entry record handed to the way
// selector, and the sweep FSM state type.
package arp_pkg;

    localparam int IP_W      = 32;
    localparam int MAC_W     = 48;
    // Widest age counter the entry record can carry. Narrower counters in
    // the cache are zero-extended into this field.
    localparam int AGE_W_MAX = 8;

    typedef struct packed {
        logic                 valid;
        logic [AGE_W_MAX-1:0] age;
        logic [MAC_W-1:0]     mac;
        logic [IP_W-1:0]      ip;
    } entry_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_AGE,
        S_FLUSH
    } state_t;

endpackage

// File: rtl/arp_way_select.sv
// Combinational way selection for one set of the ARP cache.
// Ports:
//   entries    - the WAYS entries of the addressed set
//   key        - IP address being looked up / written
//   hit        - per-way match (valid and ip == key)
//   hit_way    - lowest matching way (0 when nothing matches)
//   victim_way - lowest invalid way, else the valid way with the smallest
//                age, ties going to the lowest index
module arp_way_select
    import arp_pkg::*;
#(
    parameter int WAYS  = 2,
    parameter int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  entry_t [WAYS-1:0] entries,
    input  logic [IP_W-1:0]   key,
    output logic [WAYS-1:0]   hit,
    output logic [WAY_W-1:0]  hit_way,
    output logic [WAY_W-1:0]  victim_way
);

    logic                 found_inv;
    logic [AGE_W_MAX-1:0] best_age;
    logic [MAC_W-1:0]     unused_mac_fold;

    always_comb begin
        hit             = '0;
        hit_way         = '0;
        victim_way      = '0;
        found_inv       = 1'b0;
        best_age        = entries[0].age;
        unused_mac_fold = '0;

        for (int w = 0; w < WAYS; w++) begin
            hit[w]          = entries[w].valid && (entries[w].ip == key);
            unused_mac_fold = unused_mac_fold ^ entries[w].mac;
        end

        // Scan downwards so the lowest qualifying index is the last written.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (hit[w]) begin
                hit_way = WAY_W'(w);
            end
        end

        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!entries[w].valid) begin
                victim_way = WAY_W'(w);
                found_inv  = 1'b1;
            end
        end

        // Set is full: evict the oldest (smallest remaining age). Strict
        // less-than keeps ties on the lowest index.
        if (!found_inv) begin
            for (int w = 1; w < WAYS; w++) begin
                if (entries[w].age < best_age) begin
                    best_age   = entries[w].age;
                    victim_way = WAY_W'(w);
                end
            end
        end
    end

endmodule

// File: rtl/arp_cache_assoc.sv
// N-way set-associative IPv4-to-MAC cache.
// Ports:
//   clk, reset            - clock; asynchronous active-high reset
//   req_valid, req_ip     - lookup request
//   rsp_valid, rsp_found,
//   rsp_mac               - registered lookup result, one cycle after req
//   wr_valid, wr_ip,
//   wr_mac, wr_ready      - insert/update; accepted when wr_ready=1
//   age_tick              - starts an aging sweep over all sets
//   flush                 - starts a clearing sweep over all sets
//   busy                  - high while the flush sweep runs
// Parameters must satisfy HASH_LSB + HASH_DEPTH <= 32, 1 <= WAYS <= 4,
// AGE_BITS <= AGE_W_MAX and 1 <= MAX_AGE <= 2^AGE_BITS-1.
module arp_cache_assoc
    import arp_pkg::*;
#(
    parameter int HASH_DEPTH = 8,
    parameter int HASH_LSB   = 24,
    parameter int WAYS       = 2,
    parameter int AGE_BITS   = 4,
    parameter int MAX_AGE    = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [IP_W-1:0]  req_ip,
    output logic             rsp_valid,
    output logic             rsp_found,
    output logic [MAC_W-1:0] rsp_mac,
    input  logic             wr_valid,
    input  logic [IP_W-1:0]  wr_ip,
    input  logic [MAC_W-1:0] wr_mac,
    output logic             wr_ready,
    input  logic             age_tick,
    input  logic             flush,
    output logic             busy
);

    localparam int NUM_SETS = 1 << HASH_DEPTH;
    localparam int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [HASH_DEPTH-1:0] LAST_SET = '1;

    // Entry storage: valid/age are flops, ip/mac carry no reset so they can
    // map onto RAM.
    logic [WAYS-1:0]     valid_q [NUM_SETS];
    logic [AGE_BITS-1:0] age_q   [NUM_SETS][WAYS];
    logic [IP_W-1:0]     ip_mem  [NUM_SETS][WAYS];
    logic [MAC_W-1:0]    mac_mem [NUM_SETS][WAYS];

    state_t                state_q, state_d;
    logic [HASH_DEPTH-1:0] ptr_q, ptr_d;

    logic             rsp_valid_q, rsp_found_q;
    logic [MAC_W-1:0] rsp_mac_q;

    logic [HASH_DEPTH-1:0] rd_idx, wr_idx;
    entry_t [WAYS-1:0]     rd_entries, wr_entries;
    logic [WAYS-1:0]       rd_hit, wr_hit;
    logic [WAY_W-1:0]      rd_hit_way, rd_victim, wr_hit_way, wr_victim, wr_way;
    logic                  rd_found;
    logic [MAC_W-1:0]      rd_mac;
    logic                  wr_en;
    logic                  unused_sel;

    assign busy     = (state_q == S_FLUSH);
    assign wr_ready = ~busy;
    assign wr_en    = wr_valid && !busy;

    assign rd_idx = req_ip[HASH_LSB +: HASH_DEPTH];
    assign wr_idx = wr_ip[HASH_LSB +: HASH_DEPTH];

    // Both views read the pre-edge state, so a same-cycle write never
    // shows up in a same-cycle lookup.
    always_comb begin
        rd_entries = '0;
        wr_entries = '0;
        for (int w = 0; w < WAYS; w++) begin
            rd_entries[w].valid = valid_q[rd_idx][w];
            rd_entries[w].age   = AGE_W_MAX'(age_q[rd_idx][w]);
            rd_entries[w].mac   = mac_mem[rd_idx][w];
            rd_entries[w].ip    = ip_mem[rd_idx][w];
            wr_entries[w].valid = valid_q[wr_idx][w];
            wr_entries[w].age   = AGE_W_MAX'(age_q[wr_idx][w]);
            wr_entries[w].mac   = mac_mem[wr_idx][w];
            wr_entries[w].ip    = ip_mem[wr_idx][w];
        end
    end

    arp_way_select #(
        .WAYS  (WAYS),
        .WAY_W (WAY_W)
    ) u_rd_sel (
        .entries    (rd_entries),
        .key        (req_ip),
        .hit        (rd_hit),
        .hit_way    (rd_hit_way),
        .victim_way (rd_victim)
    );

    arp_way_select #(
        .WAYS  (WAYS),
        .WAY_W (WAY_W)
    ) u_wr_sel (
        .entries    (wr_entries),
        .key        (wr_ip),
        .hit        (wr_hit),
        .hit_way    (wr_hit_way),
        .victim_way (wr_victim)
    );

    assign unused_sel = ^{rd_victim};

    assign wr_way   = (|wr_hit) ? wr_hit_way : wr_victim;
    assign rd_found = req_valid && (|rd_hit) && (state_q != S_FLUSH);
    assign rd_mac   = mac_mem[rd_idx][rd_hit_way];

    // Sweep sequencing: flush wins over age_tick and aborts a running
    // aging sweep; age_tick outside IDLE is dropped.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            S_IDLE: begin
                if (flush) begin
                    state_d = S_FLUSH;
                    ptr_d   = '0;
                end else if (age_tick) begin
                    state_d = S_AGE;
                    ptr_d   = '0;
                end
            end
            S_AGE: begin
                if (flush) begin
                    state_d = S_FLUSH;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + HASH_DEPTH'(1);
                    if (ptr_q == LAST_SET) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_FLUSH: begin
                ptr_d = ptr_q + HASH_DEPTH'(1);
                if (ptr_q == LAST_SET) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_found_q <= 1'b0;
            rsp_mac_q   <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            rsp_valid_q <= req_valid;
            rsp_found_q <= rd_found;
            rsp_mac_q   <= rd_found ? rd_mac : '0;
        end
    end

    // The write is issued last so that, when it lands in the set being
    // aged, its valid=1/age=MAX_AGE overrides the decrement for that way
    // while the other ways keep theirs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    age_q[s][w] <= '0;
                end
            end
        end else begin
            if (state_q == S_AGE) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (valid_q[ptr_q][w]) begin
                        age_q[ptr_q][w] <= age_q[ptr_q][w] - AGE_BITS'(1);
                        if (age_q[ptr_q][w] <= AGE_BITS'(1)) begin
                            valid_q[ptr_q][w] <= 1'b0;
                        end
                    end
                end
            end
            if (state_q == S_FLUSH) begin
                valid_q[ptr_q] <= '0;
            end
            if (wr_en) begin
                valid_q[wr_idx][wr_way] <= 1'b1;
                age_q[wr_idx][wr_way]   <= AGE_BITS'(MAX_AGE);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            ip_mem[wr_idx][wr_way]  <= wr_ip;
            mac_mem[wr_idx][wr_way] <= wr_mac;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_found = rsp_found_q;
    assign rsp_mac   = rsp_mac_q;

endmodule
